// File: rtl/if_stage_if.sv
// Signal bundle for the fetch stage: PC-stage controls, instruction-RAM port and ID-side outputs.
interface if_stage_if #(
   parameter int unsigned IMEM_AW = 12
);
   logic               cpu_run;
   logic               stall;
   logic               flush;
   logic [29:0]        pc;
   logic               pc_adv;
   logic [IMEM_AW-1:0] imem_radr;
   logic [31:0]        imem_rdata;
   logic [31:0]        inst_id;
   logic [29:0]        pc_id;
   logic               inst_valid_id;
   logic               fetch_fault_id;

   modport master (
      input  cpu_run, stall, flush, pc, pc_adv, imem_rdata,
      output imem_radr, inst_id, pc_id, inst_valid_id, fetch_fault_id
   );

   modport slave (
      output cpu_run, stall, flush, pc, pc_adv, imem_rdata,
      input  imem_radr, inst_id, pc_id, inst_valid_id, fetch_fault_id
   );
endinterface

// File: rtl/if_stage.sv
// Instruction fetch stage: tracks the in-flight synchronous-RAM read and presents the
// fetched word to decode, with a one-entry skid buffer so a stall never loses a word.
module if_stage #(
   parameter int unsigned IMEM_AW  = 12,
   parameter logic [31:0] NOP_INST = 32'h00000013
) (
   input logic        clk,
   input logic        rst,
   if_stage_if.master bus
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
   localparam logic [1:0] S_HOLD = 2'd2;

   logic [1:0]  state_q, state_d;

   logic [29:0] pc_f1_q, pc_f1_d;
   logic        valid_f1_q, valid_f1_d;
   logic        fault_f1_q, fault_f1_d;

   logic [31:0] skid_inst_q, skid_inst_d;
   logic [29:0] skid_pc_q, skid_pc_d;
   logic        skid_valid_q, skid_valid_d;
   logic        skid_fault_q, skid_fault_d;
   logic        skid_vld_q, skid_vld_d;

   logic [31:0] inst_id_q, inst_id_d;
   logic [29:0] pc_id_q, pc_id_d;
   logic        inst_valid_q, inst_valid_d;
   logic        fault_id_q, fault_id_d;

   logic        pc_out_of_range;
   logic        skid_live;

   assign bus.imem_radr      = bus.pc[IMEM_AW-1:0];
   assign bus.inst_id        = inst_id_q;
   assign bus.pc_id          = pc_id_q;
   assign bus.inst_valid_id  = inst_valid_q;
   assign bus.fetch_fault_id = fault_id_q;

   assign pc_out_of_range = |bus.pc[29:IMEM_AW];
   assign skid_live       = skid_vld_q & skid_valid_q;

   always_comb begin
      state_d      = state_q;
      pc_f1_d      = pc_f1_q;
      valid_f1_d   = valid_f1_q;
      fault_f1_d   = fault_f1_q;
      skid_inst_d  = skid_inst_q;
      skid_pc_d    = skid_pc_q;
      skid_valid_d = skid_valid_q;
      skid_fault_d = skid_fault_q;
      skid_vld_d   = skid_vld_q;
      inst_id_d    = inst_id_q;
      pc_id_d      = pc_id_q;
      inst_valid_d = inst_valid_q;
      fault_id_d   = fault_id_q;

      if (!bus.cpu_run || bus.flush) begin
         state_d      = bus.cpu_run ? S_RUN : S_IDLE;
         valid_f1_d   = 1'b0;
         skid_vld_d   = 1'b0;
         inst_valid_d = 1'b0;
         fault_id_d   = 1'b0;
         inst_id_d    = NOP_INST;
      end else begin
         case (state_q)
            S_IDLE: state_d = S_RUN;
            S_RUN: begin
               if (bus.stall) begin
                  skid_inst_d  = bus.imem_rdata;
                  skid_pc_d    = pc_f1_q;
                  skid_valid_d = valid_f1_q;
                  skid_fault_d = fault_f1_q;
                  skid_vld_d   = 1'b1;
                  state_d      = S_HOLD;
               end else begin
                  pc_f1_d      = bus.pc;
                  valid_f1_d   = bus.pc_adv;
                  fault_f1_d   = pc_out_of_range;
                  pc_id_d      = pc_f1_q;
                  inst_valid_d = valid_f1_q;
                  fault_id_d   = fault_f1_q & valid_f1_q;
                  inst_id_d    = (valid_f1_q && !fault_f1_q) ? bus.imem_rdata : NOP_INST;
               end
            end
            S_HOLD: begin
               // Release cycle also captures the new fetch; otherwise the word issued
               // while the skid entry drains would be dropped.
               if (!bus.stall) begin
                  pc_f1_d      = bus.pc;
                  valid_f1_d   = bus.pc_adv;
                  fault_f1_d   = pc_out_of_range;
                  pc_id_d      = skid_pc_q;
                  inst_valid_d = skid_live;
                  fault_id_d   = skid_live & skid_fault_q;
                  inst_id_d    = (skid_live && !skid_fault_q) ? skid_inst_q : NOP_INST;
                  skid_vld_d   = 1'b0;
                  state_d      = S_RUN;
               end
            end
            default: state_d = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= S_IDLE;
         pc_f1_q      <= '0;
         valid_f1_q   <= 1'b0;
         fault_f1_q   <= 1'b0;
         skid_inst_q  <= NOP_INST;
         skid_pc_q    <= '0;
         skid_valid_q <= 1'b0;
         skid_fault_q <= 1'b0;
         skid_vld_q   <= 1'b0;
         inst_id_q    <= NOP_INST;
         pc_id_q      <= '0;
         inst_valid_q <= 1'b0;
         fault_id_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         pc_f1_q      <= pc_f1_d;
         valid_f1_q   <= valid_f1_d;
         fault_f1_q   <= fault_f1_d;
         skid_inst_q  <= skid_inst_d;
         skid_pc_q    <= skid_pc_d;
         skid_valid_q <= skid_valid_d;
         skid_fault_q <= skid_fault_d;
         skid_vld_q   <= skid_vld_d;
         inst_id_q    <= inst_id_d;
         pc_id_q      <= pc_id_d;
         inst_valid_q <= inst_valid_d;
         fault_id_q   <= fault_id_d;
      end
   end

endmodule
